// File: rtl/ppc_types.sv
// Shared LSU/data-memory types: request record, adapter FSM states and
// small byte-lane helpers used by the data memory adapter.
package ppc_types;

    // Tag field is sized for the widest reservation-station id in use.
    localparam int LSU_TAG_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_LO = 2'd1,
        ISSUE_HI = 2'd2,
        RESP     = 2'd3
    } dmem_adapter_state_t;

    // Request as latched from the LSU. Masks and data are left-justified,
    // lane 0 (MSB byte) first.
    typedef struct packed {
        logic [31:0]          addr;
        logic [3:0]           write_en;
        logic [3:0]           read_en;
        logic [31:0]          wdata;
        logic [LSU_TAG_W-1:0] tag;
        logic [4:0]           reg_addr;
    } lsu_mem_req_t;

    function automatic logic [2:0] popcount4(input logic [3:0] m);
        return {2'b00, m[3]} + {2'b00, m[2]} + {2'b00, m[1]} + {2'b00, m[0]};
    endfunction

    // Access runs past the end of the word when offset + size exceeds 4.
    function automatic logic is_split(input logic [1:0] off, input logic [2:0] n);
        return ({2'b00, off} + {1'b0, n}) > 4'd4;
    endfunction

    // Rotate right by whole bytes (moves lane 0 towards lane 3).
    function automatic logic [31:0] rotr_bytes(input logic [31:0] x, input logic [1:0] o);
        case (o)
            2'd1:    return {x[7:0],  x[31:8]};
            2'd2:    return {x[15:0], x[31:16]};
            2'd3:    return {x[23:0], x[31:24]};
            default: return x;
        endcase
    endfunction

    // Rotate left by whole bytes (moves lane o to lane 0).
    function automatic logic [31:0] rotl_bytes(input logic [31:0] x, input logic [1:0] o);
        case (o)
            2'd1:    return {x[23:0], x[31:24]};
            2'd2:    return {x[15:0], x[31:16]};
            2'd3:    return {x[7:0],  x[31:8]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_mem_adapter_completion_fifo.sv
// In-order completion FIFO. Outputs come straight from storage flops; a
// push and a pop may happen in the same cycle. Caller never pushes when full.
module completion_fifo
    import ppc_types::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;

    assign do_pop    = pop && (count_q != '0);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rptr_q];
    assign count     = count_q;

    // Storage, pointers and occupancy; reset clears entries so outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= push_data;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/lsu_data_mem_adapter.sv
// LSU <-> synchronous data SRAM adapter: lane steering for stores, two-beat
// split of word-crossing accesses, load merge/right-justify, and buffered
// in-order completions (one per accepted request).
module lsu_data_mem_adapter
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int RESP_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   to_mem_valid,
    output logic                   to_mem_ready,
    input  logic [RS_ID_WIDTH-1:0] to_mem_rs_id,
    input  logic [4:0]             to_mem_reg_addr,
    input  logic [31:0]            mem_address,
    input  logic [3:0]             mem_write_en,
    input  logic [31:0]            mem_write_data,
    input  logic [3:0]             mem_read_en,
    output logic                   from_mem_valid,
    input  logic                   from_mem_ready,
    output logic [RS_ID_WIDTH-1:0] from_mem_rs_id,
    output logic [4:0]             from_mem_reg_addr,
    output logic [31:0]            mem_read_data,
    output logic                   dmem_en,
    output logic [29:0]            dmem_addr,
    output logic [3:0]             dmem_we,
    output logic [31:0]            dmem_wdata,
    input  logic [31:0]            dmem_rdata
);

    localparam int CNT_W = $clog2(RESP_DEPTH) + 1;
    localparam int PAY_W = RS_ID_WIDTH + 5 + 32;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RESP_DEPTH);

    dmem_adapter_state_t state_q, state_d;
    lsu_mem_req_t        req_in, req_q;

    logic             ready_q, handshake, push, pop;
    logic [CNT_W-1:0] fifo_count, count_nxt;
    logic [PAY_W-1:0] push_data, pop_data;
    logic [31:0]      lo_q;

    // Attributes of the latched request
    logic [1:0] off_q;
    logic [3:0] mask_q;
    logic [2:0] n_q;
    logic       store_q, split_q;

    // Next-cycle SRAM drive
    logic [31:0] act_addr, act_wdata;
    logic [3:0]  act_we, act_mask, lanes;
    logic [1:0]  act_off;
    logic        en_d;
    logic [29:0] addr_d;
    logic [3:0]  we_d;
    logic [31:0] wdata_d;

    // Load result path
    logic [31:0] merged, rotated, result;

    // Tag bits above RS_ID_WIDTH are never populated.
    logic unused_tag_hi;
    assign unused_tag_hi = ^(req_q.tag >> RS_ID_WIDTH);

    assign to_mem_ready = ready_q;
    assign handshake    = to_mem_valid && ready_q;

    assign req_in = '{addr:     mem_address,
                      write_en: mem_write_en,
                      read_en:  mem_read_en,
                      wdata:    mem_write_data,
                      tag:      LSU_TAG_W'(to_mem_rs_id),
                      reg_addr: to_mem_reg_addr};

    assign off_q   = req_q.addr[1:0];
    assign mask_q  = req_q.write_en | req_q.read_en;
    assign n_q     = popcount4(mask_q);
    assign store_q = |req_q.write_en;
    assign split_q = is_split(off_q, n_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a request with no mask bits skips the SRAM entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (handshake)
                          state_d = ((mem_write_en | mem_read_en) == 4'b0000) ? RESP : ISSUE_LO;
            ISSUE_LO: state_d = split_q ? ISSUE_HI : RESP;
            ISSUE_HI: state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output logic: SRAM beat for the state being entered. In IDLE the
    // request is still on the input port, so steer from there.
    always_comb begin
        act_addr  = (state_q == IDLE) ? mem_address    : req_q.addr;
        act_we    = (state_q == IDLE) ? mem_write_en   : req_q.write_en;
        act_mask  = (state_q == IDLE) ? (mem_write_en | mem_read_en) : mask_q;
        act_wdata = (state_q == IDLE) ? mem_write_data : req_q.wdata;
        act_off   = act_addr[1:0];
        lanes     = '0;
        en_d      = 1'b0;
        addr_d    = '0;
        we_d      = '0;
        wdata_d   = '0;
        if (state_d == ISSUE_LO || state_d == ISSUE_HI) begin
            en_d    = 1'b1;
            wdata_d = rotr_bytes(act_wdata, act_off);
            if (state_d == ISSUE_LO) begin
                addr_d = act_addr[31:2];
                lanes  = act_mask >> act_off;
            end else begin
                addr_d = act_addr[31:2] + 30'd1;
                lanes  = act_mask << (3'd4 - {1'b0, act_off});
            end
            we_d = (|act_we) ? lanes : 4'b0000;
        end
    end

    // Registered SRAM port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_en    <= 1'b0;
            dmem_addr  <= '0;
            dmem_we    <= '0;
            dmem_wdata <= '0;
        end else begin
            dmem_en    <= en_d;
            dmem_addr  <= addr_d;
            dmem_we    <= we_d;
            dmem_wdata <= wdata_d;
        end
    end

    // Request latch and lo-beat read capture (lo data lands during ISSUE_HI)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            lo_q  <= '0;
        end else begin
            if (handshake)           req_q <= req_in;
            if (state_q == ISSUE_HI) lo_q  <= dmem_rdata;
        end
    end

    // Merge beats, bring the first byte to lane 0, then right-justify
    always_comb begin
        merged = dmem_rdata;
        if (split_q) begin
            for (int i = 0; i < 4; i++)
                if (2'(i) >= off_q) merged[31-8*i -: 8] = lo_q[31-8*i -: 8];
        end
        rotated = rotl_bytes(merged, off_q);
        result  = (store_q || n_q == 3'd0) ? 32'h0 : (rotated >> (6'd32 - {n_q, 3'b000}));
    end

    assign push      = (state_q == RESP);
    assign push_data = {req_q.tag[RS_ID_WIDTH-1:0], req_q.reg_addr, result};
    assign pop       = from_mem_valid && from_mem_ready;
    assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

    // Ready only in IDLE with room left after this cycle's push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= (state_d == IDLE) && (count_nxt < DEPTH_C);
    end

    completion_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (PAY_W)
    ) u_cpl_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .out_valid (from_mem_valid),
        .out_data  (pop_data),
        .count     (fifo_count)
    );

    assign {from_mem_rs_id, from_mem_reg_addr, mem_read_data} = pop_data;

endmodule

// File: tb/tb_lsu_data_mem_adapter.sv
// Self-checking bench: byte-addressed reference memory + completion queue,
// directed cases with literal expectations, then randomized traffic.
module tb_lsu_data_mem_adapter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        to_mem_valid, to_mem_ready;
    logic [4:0]  to_mem_rs_id, to_mem_reg_addr;
    logic [31:0] mem_address, mem_write_data;
    logic [3:0]  mem_write_en, mem_read_en;
    logic        from_mem_valid, from_mem_ready;
    logic [4:0]  from_mem_rs_id, from_mem_reg_addr;
    logic [31:0] mem_read_data;
    logic        dmem_en;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata, dmem_rdata;

    lsu_data_mem_adapter #(.RS_ID_WIDTH(5), .RESP_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .to_mem_valid(to_mem_valid), .to_mem_ready(to_mem_ready),
        .to_mem_rs_id(to_mem_rs_id), .to_mem_reg_addr(to_mem_reg_addr),
        .mem_address(mem_address), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_read_en(mem_read_en),
        .from_mem_valid(from_mem_valid), .from_mem_ready(from_mem_ready),
        .from_mem_rs_id(from_mem_rs_id), .from_mem_reg_addr(from_mem_reg_addr),
        .mem_read_data(mem_read_data),
        .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [4:0] rs; logic [4:0] rg; logic [31:0] d; } exp_t;
    exp_t exp_q[$];

    logic [31:0] sram    [logic [29:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    int          acc_cnt = 0;
    int          nb, lat;
    logic [29:0] b_addr [2];
    logic [3:0]  b_we   [2];
    logic [31:0] b_wd   [2];
    logic [31:0] res;
    logic [4:0]  res_rs;
    logic        done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return ({2'b00, w} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] sram_rd(input logic [29:0] w);
        return sram.exists(w) ? sram[w] : init_word(w);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        logic [31:0] wd;
        int l;
        if (ref_mem.exists(a)) return ref_mem[a];
        wd = init_word(a[31:2]);
        l  = int'(a[1:0]);
        return wd[31-8*l -: 8];
    endfunction

    // Big-endian bytes a..a+n-1, right-justified, zero-extended.
    function automatic logic [31:0] model_load(input logic [31:0] a, input int n);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < n; i++) r = {r[23:0], ref_rd(a + i)};
        return r;
    endfunction

    function automatic int popcnt(input logic [3:0] m);
        return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
    endfunction

    task automatic preload(input logic [29:0] w, input logic [31:0] d);
        sram[w] = d;
        for (int l = 0; l < 4; l++) ref_mem[{w, 2'(l)}] = d[31-8*l -: 8];
    endtask

    // SRAM: read data one cycle after the strobe, byte-lane writes
    always @(posedge clk) begin
        logic [31:0] w;
        if (dmem_en) begin
            w = sram_rd(dmem_addr);
            dmem_rdata <= w;
            for (int l = 0; l < 4; l++)
                if (dmem_we[3-l]) w[31-8*l -: 8] = dmem_wdata[31-8*l -: 8];
            if (dmem_we != 4'b0000) sram[dmem_addr] = w;
        end
    end

    // Completion checker against the expected-completion queue
    always @(negedge clk) begin
        if (rst_n && from_mem_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_completion: got rs=%0h data=%0h want none", from_mem_rs_id, mem_read_data);
            end else begin
                chk("cpl_rs_id", 32'(from_mem_rs_id), 32'(exp_q[0].rs));
                chk("cpl_reg", 32'(from_mem_reg_addr), 32'(exp_q[0].rg));
                chk("cpl_data", mem_read_data, exp_q[0].d);
                if (from_mem_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                        input logic [3:0] re, input logic [4:0] rs, input logic [4:0] rg);
        int guard = 0;
        int n;
        exp_t e;
        logic [31:0] ba;
        @(negedge clk);
        to_mem_valid = 1'b1; mem_address = a; mem_write_en = we; mem_write_data = wd;
        mem_read_en = re; to_mem_rs_id = rs; to_mem_reg_addr = rg;
        while (!to_mem_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!to_mem_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready=0 want ready=1 addr=%0h", a);
            to_mem_valid = 1'b0;
            return;
        end
        n    = popcnt(we | re);
        e.rs = rs;
        e.rg = rg;
        e.d  = (we == 4'b0000) ? model_load(a, n) : 32'h0;
        if (we != 4'b0000)
            for (int i = 0; i < n; i++) begin
                ba = a + i;
                ref_mem[ba] = wd[31-8*i -: 8];
            end
        exp_q.push_back(e);
        acc_cnt++;
        @(posedge clk);
        #1 to_mem_valid = 1'b0;
    endtask

    // One request with the completion port open; record beats and latency
    task automatic run_dir(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                           input logic [3:0] re, input logic [4:0] rs);
        send(a, we, wd, re, rs, 5'd9);
        nb = 0; lat = 0; res = 32'hX; res_rs = 5'hX;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (dmem_en) begin
                if (nb < 2) begin
                    b_addr[nb] = dmem_addr; b_we[nb] = dmem_we; b_wd[nb] = dmem_wdata;
                end
                nb++;
            end
            if (from_mem_valid && lat == 0) begin
                lat = k; res = mem_read_data; res_rs = from_mem_rs_id;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  masks [4];
        logic [3:0]  m;
        logic [31:0] a;
        int          kind, base, guard;
        masks = '{4'h0, 4'h8, 4'hC, 4'hF};
        to_mem_valid = 0; mem_address = 0; mem_write_en = 0; mem_write_data = 0;
        mem_read_en = 0; to_mem_rs_id = 0; to_mem_reg_addr = 0; from_mem_ready = 1;
        dmem_rdata = 0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(to_mem_ready), 0);
        chk("rst_valid", 32'(from_mem_valid), 0);
        chk("rst_dmem_en", 32'(dmem_en), 0);
        chk("rst_dmem_addr", 32'(dmem_addr), 0);
        chk("rst_dmem_we", 32'(dmem_we), 0);
        chk("rst_read_data", mem_read_data, 0);
        rst_n = 1'b1;

        // aligned word store
        run_dir(32'h100, 4'hF, 32'hDEADBEEF, 4'h0, 5'd3);
        chk("st_beats", nb, 1);
        chk("st_addr", 32'(b_addr[0]), 32'h40);
        chk("st_we", 32'(b_we[0]), 32'hF);
        chk("st_wdata", b_wd[0], 32'hDEADBEEF);
        chk("st_lat", lat, 3);
        chk("st_res", res, 0);
        chk("st_rs", 32'(res_rs), 3);

        // byte load
        preload(30'h40, 32'h11223344);
        chk("pin_byte", model_load(32'h103, 1), 32'h44);
        run_dir(32'h103, 4'h0, 32'h0, 4'h8, 5'd4);
        chk("lb_beats", nb, 1);
        chk("lb_addr", 32'(b_addr[0]), 32'h40);
        chk("lb_we", 32'(b_we[0]), 0);
        chk("lb_lat", lat, 3);
        chk("lb_res", res, 32'h44);

        // split word load
        preload(30'h3F, 32'hAABBCCDD);
        chk("pin_split", model_load(32'h0FE, 4), 32'hCCDD1122);
        run_dir(32'h0FE, 4'h0, 32'h0, 4'hF, 5'd5);
        chk("lw_beats", nb, 2);
        chk("lw_addr0", 32'(b_addr[0]), 32'h3F);
        chk("lw_addr1", 32'(b_addr[1]), 32'h40);
        chk("lw_lat", lat, 4);
        chk("lw_res", res, 32'hCCDD1122);

        // split halfword store, then read it back
        run_dir(32'h0FF, 4'hC, 32'hABCD0000, 4'h0, 5'd6);
        chk("sh_beats", nb, 2);
        chk("sh_addr0", 32'(b_addr[0]), 32'h3F);
        chk("sh_we0", 32'(b_we[0]), 32'h1);
        chk("sh_wd0", 32'(b_wd[0][7:0]), 32'hAB);
        chk("sh_addr1", 32'(b_addr[1]), 32'h40);
        chk("sh_we1", 32'(b_we[1]), 32'h8);
        chk("sh_wd1", 32'(b_wd[1][31:24]), 32'hCD);
        chk("sh_lat", lat, 4);
        chk("pin_half", model_load(32'h0FF, 2), 32'hABCD);
        run_dir(32'h0FF, 4'h0, 32'h0, 4'hC, 5'd7);
        chk("lh_res", res, 32'hABCD);

        // no mask bits: no SRAM access, fast completion
        run_dir(32'h200, 4'h0, 32'h0, 4'h0, 5'd8);
        chk("nop_beats", nb, 0);
        chk("nop_lat", lat, 2);
        chk("nop_res", res, 0);

        // word address wraps past the top of memory
        run_dir(32'hFFFFFFFF, 4'h0, 32'h0, 4'hF, 5'd10);
        chk("wrap_addr0", 32'(b_addr[0]), 32'h3FFFFFFF);
        chk("wrap_addr1", 32'(b_addr[1]), 32'h0);
        chk("wrap_lat", lat, 4);

        // backpressure: two fill the FIFO, third waits for the drain
        @(posedge clk); #1 from_mem_ready = 1'b0;
        base = acc_cnt;
        send(32'h104, 4'h0, 32'h0, 4'hF, 5'd11, 5'd1);
        send(32'h108, 4'h0, 32'h0, 4'h8, 5'd12, 5'd2);
        repeat (6) @(negedge clk);
        chk("bp_ready", 32'(to_mem_ready), 0);
        chk("bp_valid", 32'(from_mem_valid), 1);
        fork
            send(32'h10C, 4'h0, 32'h0, 4'hC, 5'd13, 5'd3);
            begin
                repeat (4) @(negedge clk);
                chk("bp_third_blocked", acc_cnt - base, 2);
                @(posedge clk); #1 from_mem_ready = 1'b1;
            end
        join
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin @(negedge clk); guard++; end
        chk("bp_drained", exp_q.size(), 0);

        // reset during the hi beat of a split load
        send(32'h0FE, 4'h0, 32'h0, 4'hF, 5'd14, 5'd4);
        @(negedge clk); @(negedge clk);
        chk("rs_hi_en", 32'(dmem_en), 1);
        chk("rs_hi_addr", 32'(dmem_addr), 32'h40);
        rst_n = 1'b0;
        #1;
        chk("rs_ready", 32'(to_mem_ready), 0);
        chk("rs_valid", 32'(from_mem_valid), 0);
        chk("rs_en", 32'(dmem_en), 0);
        chk("rs_addr", 32'(dmem_addr), 0);
        chk("rs_we", 32'(dmem_we), 0);
        chk("rs_wdata", dmem_wdata, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rs_no_cpl", 32'(from_mem_valid), 0);
        run_dir(32'h103, 4'h0, 32'h0, 4'h8, 5'd15);
        chk("rs_after_lat", lat, 3);
        chk("rs_after_res", res, 32'h44);

        // randomized traffic with random completion backpressure
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    kind = $urandom_range(0, 9);
                    m    = masks[$urandom_range(0, 3)];
                    a    = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC + $urandom_range(0, 3))
                                                       : (32'h100 + $urandom_range(0, 31));
                    if (kind == 0)      send(a, 4'h0, $urandom, 4'h0, 5'($urandom), 5'($urandom));
                    else if (kind < 5)  send(a, m, $urandom, 4'h0, 5'($urandom), 5'($urandom));
                    else                send(a, 4'h0, $urandom, m, 5'($urandom), 5'($urandom));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 from_mem_ready = ($urandom_range(0, 3) != 0);
                end
                @(posedge clk);
                #1 from_mem_ready = 1'b1;
            end
        join
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin @(negedge clk); guard++; end
        chk("rand_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
